// File: rtl/cmd_seq_feeder_pkg.sv
// Shared definitions for the Knight command sequencer: FSM states, error codes,
// response bytes and common command encodings.
package cmd_seq_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_SNT  = 2'd2,
    S_WAIT_RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_BAD_RESP = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ABORT    = 2'b11
  } err_code_t;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'h5A;

  // Command word layout: [15:12] opcode, [11:4] heading, [3:0] square count
  localparam logic [15:0] CMD_CAL_GYRO  = 16'h2000;
  localparam logic [3:0]  OP_MOVE       = 4'h4;
  localparam logic [7:0]  HEAD_NORTH    = 8'h00;
  localparam logic [7:0]  HEAD_WEST     = 8'h3F;
  localparam logic [7:0]  HEAD_SOUTH    = 8'h7F;
  localparam logic [7:0]  HEAD_EAST     = 8'hBF;

  function automatic logic [15:0] make_move(input logic [7:0] heading, input logic [3:0] squares);
    return {OP_MOVE, heading, squares};
  endfunction

endpackage

// File: rtl/cmd_seq_feeder_fifo.sv
// Synchronous command FIFO with full/empty flags and a single-cycle flush.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cmd_seq_feeder.sv
// Plays queued Knight commands to RemoteComm one at a time, waiting for each
// to be sent and acknowledged before issuing the next.
module cmd_seq_feeder
  import cmd_seq_feeder_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [7:0]  ACK          = 8'hA5,
  parameter logic [23:0] TIMEOUT_CLKS = 24'hFFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_cmd,
  input  logic [15:0] i_cmd_in,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [15:0] o_cmd,
  output logic        o_snd_cmd,
  input  logic        i_cmd_snt,
  input  logic        i_resp_rdy,
  input  logic [7:0]  i_resp,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [7:0]  o_n_acked
);

  state_t      r_state, w_next_state;
  err_code_t   r_err_code;
  logic [23:0] r_tmo_cnt;
  logic [15:0] r_cmd;
  logic [15:0] w_fifo_data;
  logic [7:0]  r_n_acked;
  logic        r_snd_cmd, r_done, r_err, r_abort_pend;
  logic        w_ack, w_nak, w_timeout, w_abort_any;
  logic        w_pop, w_flush, w_start_run, w_set_done;
  logic        w_fin_ack, w_fin_abort, w_fin_nak, w_fin_tmo;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_wr_cmd),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (i_cmd_in),
    .o_data  (w_fifo_data),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  // A response arriving on the last counted clock beats the timeout
  assign w_ack       = i_resp_rdy && (i_resp == ACK);
  assign w_nak       = i_resp_rdy && (i_resp != ACK);
  assign w_timeout   = !i_resp_rdy && (r_tmo_cnt == TIMEOUT_CLKS - 24'd1);
  assign w_abort_any = r_abort_pend || i_abort;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (i_start && !i_abort && !o_empty) w_next_state = S_ISSUE;
      S_ISSUE:     w_next_state = S_WAIT_SNT;
      S_WAIT_SNT:  if (i_cmd_snt) w_next_state = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (w_ack)                 w_next_state = (!o_empty && !w_abort_any) ? S_ISSUE : S_IDLE;
        else if (w_nak || w_timeout) w_next_state = S_IDLE;
      end
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop       = (r_state == S_ISSUE);
    w_start_run = (r_state == S_IDLE) && i_start && !i_abort;
    w_fin_ack   = (r_state == S_WAIT_RESP) && w_ack;
    w_fin_nak   = (r_state == S_WAIT_RESP) && w_nak;
    w_fin_tmo   = (r_state == S_WAIT_RESP) && w_timeout;
    w_fin_abort = w_fin_ack && w_abort_any;
    w_set_done  = (w_start_run && o_empty) || (w_fin_ack && o_empty && !w_abort_any);
    w_flush     = ((r_state == S_IDLE) && i_abort) || w_fin_abort || w_fin_nak || w_fin_tmo;
    o_busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd        <= '0;
      r_snd_cmd    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_n_acked    <= '0;
      r_abort_pend <= 1'b0;
      r_tmo_cnt    <= '0;
    end else begin
      r_snd_cmd    <= w_pop;
      r_done       <= w_set_done;
      r_abort_pend <= (w_next_state != S_IDLE) && w_abort_any;
      if (w_pop) r_cmd <= w_fifo_data;
      if (w_start_run) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
        r_n_acked  <= '0;
      end
      if (w_fin_ack && (r_n_acked != 8'hFF)) r_n_acked <= r_n_acked + 8'd1;
      if (w_fin_nak) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_BAD_RESP;
      end else if (w_fin_tmo) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_TIMEOUT;
      end else if (w_fin_abort) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_ABORT;
      end
      if ((r_state == S_WAIT_SNT) && i_cmd_snt)           r_tmo_cnt <= '0;
      else if ((r_state == S_WAIT_RESP) && (r_tmo_cnt != 24'hFFFFFF)) r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end
  end

  assign o_cmd      = r_cmd;
  assign o_snd_cmd  = r_snd_cmd;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;
  assign o_n_acked  = r_n_acked;

endmodule

// File: tb/tb_cmd_seq_feeder.sv
// Scoreboard bench for cmd_seq_feeder: a RemoteComm stand-in answers each
// command, and a run-level reference model predicts commands sent and final status.
module tb_cmd_seq_feeder;
  import cmd_seq_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, wrCmd, start, abortIn, cmdSnt, respRdy;
  logic [15:0] cmdIn, cmdOut;
  logic [7:0]  resp, nAcked;
  logic        sndCmd, full, empty, busy, done, err;
  logic [1:0]  errCode;

  int          total = 0;
  int          bad = 0;
  int          cycCnt = 0;
  int          doneCount = 0;
  int          doneBase = 0;
  int          sntEdge = 0;
  int          fixedSnt = -1;
  int          fixedResp = -1;
  bit          remoteBusy = 1'b0;
  bit          inWaitResp = 1'b0;
  logic [15:0] expCmdQ[$];
  int          respPlan[$];
  int          expAcked, expCode;
  bit          expDone;

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  cmd_seq_feeder #(.DEPTH(16), .ACK(8'hA5), .TIMEOUT_CLKS(24'd1000)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_cmd   (wrCmd),
    .i_cmd_in   (cmdIn),
    .i_start    (start),
    .i_abort    (abortIn),
    .o_cmd      (cmdOut),
    .o_snd_cmd  (sndCmd),
    .i_cmd_snt  (cmdSnt),
    .i_resp_rdy (respRdy),
    .i_resp     (resp),
    .o_full     (full),
    .o_empty    (empty),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (errCode),
    .o_n_acked  (nAcked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Each snd_cmd pulse must carry the oldest still-expected command
  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (done) doneCount++;
      if (sndCmd) begin
        if (expCmdQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_snd_cmd: got cmd=%h expected no command", cmdOut);
        end else begin
          checkOutput("cmd_order", 32'(cmdOut), 32'(expCmdQ.pop_front()));
        end
      end
    end
  endtask

  // RemoteComm stand-in: resp plan entry < 0 means stay silent
  task automatic remoteLoop();
    int d;
    int r;
    forever begin
      tick();
      if (sndCmd) begin
        remoteBusy = 1'b1;
        d = (fixedSnt >= 0) ? fixedSnt : int'($urandom_range(0, 3));
        repeat (d) tick();
        cmdSnt  = 1'b1;
        sntEdge = cycCnt + 1;
        tick();
        cmdSnt     = 1'b0;
        inWaitResp = 1'b1;
        r = (respPlan.size() > 0) ? respPlan.pop_front() : 32'hA5;
        if (r >= 0) begin
          d = (fixedResp >= 0) ? fixedResp : int'($urandom_range(0, 5));
          repeat (d) tick();
          respRdy = 1'b1;
          resp    = r[7:0];
          tick();
          respRdy = 1'b0;
        end
        inWaitResp = 1'b0;
        remoteBusy = 1'b0;
      end
    end
  endtask

  // Run-level model: commands go out in order until a non-ACK reply or an abort
  task automatic modelRun(input logic [15:0] cmds[$], input int resps[$], input int abortIdx);
    expAcked = 0;
    expCode  = 0;
    expDone  = 1'b1;
    for (int i = 0; i < cmds.size(); i++) begin
      expCmdQ.push_back(cmds[i]);
      respPlan.push_back(resps[i]);
      if (resps[i] == 32'hA5) begin
        expAcked++;
        if (i == abortIdx) begin
          expCode = 3;
          expDone = 1'b0;
          break;
        end
      end else begin
        expCode = (resps[i] < 0) ? 2 : 1;
        expDone = 1'b0;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] cmds[$], input int resps[$], input int abortIdx);
    doneBase = doneCount;
    modelRun(cmds, resps, abortIdx);
    foreach (cmds[i]) begin
      wrCmd = 1'b1;
      cmdIn = cmds[i];
      tick();
    end
    wrCmd = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while ((busy || remoteBusy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_hang: got busy after %0d cycles expected idle", name, n);
    end
    tick();
  endtask

  task automatic checkRun(input string name);
    waitIdle(name, 3000);
    checkOutput({name, "_n_acked"}, 32'(nAcked), 32'(expAcked));
    checkOutput({name, "_err"}, 32'(err), 32'(expCode != 0));
    checkOutput({name, "_err_code"}, 32'(errCode), 32'(expCode));
    checkOutput({name, "_done_count"}, 32'(doneCount - doneBase), 32'(expDone));
    checkOutput({name, "_empty"}, 32'(empty), 32'd1);
    checkOutput({name, "_scoreboard_left"}, 32'(expCmdQ.size()), 32'd0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_cmd"}, 32'(cmdOut), 32'd0);
    checkOutput({name, "_snd_cmd"}, 32'(sndCmd), 32'd0);
    checkOutput({name, "_done"}, 32'(done), 32'd0);
    checkOutput({name, "_err"}, 32'(err), 32'd0);
    checkOutput({name, "_err_code"}, 32'(errCode), 32'd0);
    checkOutput({name, "_n_acked"}, 32'(nAcked), 32'd0);
    checkOutput({name, "_full"}, 32'(full), 32'd0);
    checkOutput({name, "_empty"}, 32'(empty), 32'd1);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] cmds[$];
    int          resps[$];
    int          n;
    int          pos;
    int          errEdge;
    rst = 1'b1; wrCmd = 1'b0; start = 1'b0; abortIn = 1'b0;
    cmdIn = '0; cmdSnt = 1'b0; respRdy = 1'b0; resp = '0;
    fork
      monitorLoop();
      remoteLoop();
    join_none
    repeat (3) tick();
    rst = 1'b0;
    checkResetState("reset");

    // Calibrate then move south 3, both acknowledged
    cmds = '{CMD_CAL_GYRO, make_move(HEAD_SOUTH, 4'd3)};
    resps = '{32'hA5, 32'hA5};
    applyStimulus(cmds, resps, -1);
    checkRun("two_acks");

    // Second of three commands gets a NAK
    cmds = '{16'h2000, 16'h4003, 16'h4BF2};
    resps = '{32'hA5, 32'h5A, 32'hA5};
    applyStimulus(cmds, resps, -1);
    checkRun("nak");

    // Start with an empty FIFO pulses done the next cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty_start_done", 32'(done), 32'd1);
    checkOutput("empty_start_busy", 32'(busy), 32'd0);
    tick();

    // Randomized runs: all-ACK or one bad reply at a random position
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 8);
      pos = (k % 2 == 1) ? int'($urandom_range(0, n - 1)) : -1;
      cmds.delete();
      resps.delete();
      for (int j = 0; j < n; j++) begin
        cmds.push_back(16'($urandom));
        resps.push_back((j == pos) ? ((k == 5) ? -1 : int'($urandom_range(0, 164))) : 32'hA5);
      end
      applyStimulus(cmds, resps, -1);
      checkRun($sformatf("rand%0d", k));
    end

    // Timeout: exactly 1000 clocks from the cmd_snt sample edge to err
    cmds = '{16'h47F3};
    resps = '{-1};
    applyStimulus(cmds, resps, -1);
    n = 0;
    while (!err && n < 2000) begin
      tick();
      n++;
    end
    errEdge = cycCnt;
    checkOutput("timeout_latency", 32'(errEdge - sntEdge), 32'd1000);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkRun("timeout");

    // Fill to DEPTH, drop an extra, then push while popping at full
    cmds.delete();
    resps.delete();
    for (int j = 0; j < 16; j++) cmds.push_back(16'h1000 + 16'(j));
    foreach (cmds[i]) begin
      wrCmd = 1'b1;
      cmdIn = cmds[i];
      tick();
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_empty", 32'(empty), 32'd0);
    cmdIn = 16'hDEAD;
    tick();
    wrCmd = 1'b0;
    checkOutput("overflow_full", 32'(full), 32'd1);
    cmds.push_back(16'hBEEF);
    for (int j = 0; j < 17; j++) resps.push_back(32'hA5);
    doneBase = doneCount;
    modelRun(cmds, resps, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wrCmd = 1'b1;
    cmdIn = 16'hBEEF;
    tick();
    wrCmd = 1'b0;
    checkOutput("push_pop_full", 32'(full), 32'd1);
    checkRun("full_run");

    // Abort while waiting for the reply to the first of three
    fixedResp = 6;
    cmds = '{16'h4003, 16'h43F1, 16'h47F2};
    resps = '{32'hA5, 32'hA5, 32'hA5};
    applyStimulus(cmds, resps, 0);
    n = 0;
    while (!inWaitResp && n < 100) begin
      tick();
      n++;
    end
    checkOutput("abort_reach_wait_resp", 32'(inWaitResp), 32'd1);
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    checkRun("abort");
    fixedResp = -1;

    // Reset while waiting for cmd_snt; late handshakes must be ignored
    fixedSnt = 3;
    expCmdQ.push_back(16'h4BF1);
    respPlan.push_back(32'hA5);
    wrCmd = 1'b1;
    cmdIn = 16'h4BF1;
    tick();
    cmdIn = 16'h4001;
    tick();
    wrCmd = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!sndCmd && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rst_saw_snd", 32'(sndCmd), 32'd1);
    rst = 1'b1;
    tick();
    checkResetState("mid_rst");
    rst = 1'b0;
    waitIdle("post_rst", 100);
    repeat (4) tick();
    checkOutput("post_rst_n_acked", 32'(nAcked), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_err", 32'(err), 32'd0);
    checkOutput("post_rst_scoreboard_left", 32'(expCmdQ.size()), 32'd0);
    fixedSnt = -1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
